// File: rtl/click_pkg.sv
// Shared types and helpers for the click gesture decoder.
//  click_state_t : gesture FSM state (IDLE = no gesture open, WAIT = gesture open)
//  clog2_safe    : ceil(log2(n)), never less than 1, for register widths
package click_pkg;

   typedef enum logic {IDLE, WAIT} click_state_t;

   function automatic int unsigned clog2_safe(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((2 ** w) < n) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/click_window_timer.sv
// Inactivity window timer for the click decoder.
//  clk     : system clock, rising edge
//  rst     : synchronous active-high reset, clears the counter
//  clear   : restart the window (counter back to 0), priority over en
//  en      : advance the counter by one, saturating at WINDOW-1
//  expired : counter has reached WINDOW-1
module click_window_timer
   import click_pkg::*;
#(
   parameter int unsigned WINDOW = 50
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic expired
);

   localparam int unsigned TMR_W = clog2_safe(WINDOW);

   logic [TMR_W-1:0] tmr_q;
   logic [TMR_W-1:0] tmr_d;

   assign expired = (tmr_q == TMR_W'(WINDOW - 1));

   always_comb begin
      tmr_d = tmr_q;
      if (clear) begin
         tmr_d = '0;
      end else if (en && !expired) begin
         tmr_d = tmr_q + TMR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tmr_q <= '0;
      end else begin
         tmr_q <= tmr_d;
      end
   end

endmodule

// File: rtl/click_decoder.sv
// Groups single-cycle tick pulses into multi-click gestures. A gesture closes
// after WINDOW tick-free cycles or as soon as MAX_CLICKS ticks have arrived.
//  clk   : system clock, rising edge
//  rst   : synchronous active-high reset, discards any open gesture
//  tick  : 1-cycle click pulse, may be high on consecutive cycles
//  done  : 1-cycle strobe, gesture complete and count valid
//  count : clicks in the last gesture, held until the next done
//  busy  : a gesture is open
module click_decoder
   import click_pkg::*;
#(
   parameter int unsigned WINDOW     = 50,
   parameter int unsigned MAX_CLICKS = 3
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                tick,
   output logic                                done,
   output logic [clog2_safe(MAX_CLICKS+1)-1:0] count,
   output logic                                busy
);

   localparam int unsigned CNT_W = clog2_safe(MAX_CLICKS + 1);

   click_state_t     state_q, state_d;
   logic [CNT_W-1:0] clicks_q, clicks_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] clicks_inc;
   logic             tmr_clear;
   logic             tmr_en;
   logic             expired;

   // The timer is held at zero outside a gesture and restarted by every tick,
   // so the window always measures time since the most recent click.
   assign tmr_clear = tick || (state_q == IDLE);
   assign tmr_en    = (state_q == WAIT);

   click_window_timer #(
      .WINDOW (WINDOW)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (tmr_clear),
      .en      (tmr_en),
      .expired (expired)
   );

   assign clicks_inc = clicks_q + CNT_W'(1);

   always_comb begin
      state_d  = state_q;
      clicks_d = clicks_q;
      count_d  = count_q;
      done_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (tick) begin
               clicks_d = CNT_W'(1);
               if (MAX_CLICKS == 1) begin
                  done_d  = 1'b1;
                  count_d = CNT_W'(1);
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            // A tick on the timeout edge extends the gesture instead of closing it.
            if (tick) begin
               clicks_d = clicks_inc;
               if (clicks_inc == CNT_W'(MAX_CLICKS)) begin
                  done_d  = 1'b1;
                  count_d = clicks_inc;
                  state_d = IDLE;
               end
            end else if (expired) begin
               done_d  = 1'b1;
               count_d = clicks_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         clicks_q <= '0;
         count_q  <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         clicks_q <= clicks_d;
         count_q  <= count_d;
         done_q   <= done_d;
      end
   end

   assign done  = done_q;
   assign count = count_q;
   assign busy  = (state_q == WAIT);

endmodule
